// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter sharing one sync_fifo write port among NUM_REQ
//   producers. One word is written per cycle at most. A producer can lock
//   the port for a burst of up to MAX_BURST words. Every write is gated by
//   fifo_full, so the shared FIFO cannot overflow.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-high reset
//   req         in   [NUM_REQ]        per-producer write request, held until ack
//   lock        in   [NUM_REQ]        per-producer burst request, sampled with req
//   din_bus     in   [NUM_REQ*Width]  producer data, slice i = [i*Width +: Width]
//   ack         out  [NUM_REQ]        one-hot, producer word written this cycle
//   fifo_full   in                    FIFO full flag
//   fifo_w_enb  out                   FIFO write enable
//   fifo_din    out  [Width]          FIFO write data
//   grant_id    out  [clog2(NUM_REQ)] producer being written, 0 when idle
//   busy        out                   high while a burst is locked
//   stall_cnt   out  [16]             only with FIFO_ARB_STATS_EN defined
//
// Build option
//   FIFO_ARB_STATS_EN : adds a saturating stall counter (cycles with any
//                       request pending while the FIFO is full).
//
// FSM states
//   state    | meaning
//   ST_IDLE  | round-robin among all requesters, one word per cycle
//   ST_BURST | port locked to owner until lock drops, req drops or MAX_BURST words

module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int Width     = 16,
  parameter int MAX_BURST = 4,
  localparam int IdW      = $clog2(NUM_REQ),
  localparam int CntW     = $clog2(MAX_BURST + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*Width-1:0] din_bus,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     fifo_full,
  output logic                     fifo_w_enb,
  output logic [Width-1:0]         fifo_din,
  output logic [IdW-1:0]           grant_id,
  output logic                     busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [IdW-1:0]  last_grant, last_grant_nxt;
  logic [IdW-1:0]  owner, owner_nxt;
  logic [CntW-1:0] burst_cnt, burst_cnt_nxt;
  logic [CntW-1:0] burst_cnt_inc;

  logic            rr_hit;
  logic [IdW-1:0]  rr_idx;
  int              rr_k;

  logic            wr_go;
  logic [IdW-1:0]  wr_sel;

  // Round-robin search starting just after the last granted producer.
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_k   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_k = int'(last_grant) + i;
      if (rr_k >= NUM_REQ) rr_k = rr_k - NUM_REQ;
      if (!rr_hit && req[rr_k[IdW-1:0]]) begin
        rr_hit = 1'b1;
        rr_idx = rr_k[IdW-1:0];
      end
    end
  end

  assign burst_cnt_inc = burst_cnt + CntW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= IdW'(NUM_REQ - 1);
      owner      <= '0;
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      owner      <= owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    owner_nxt      = owner;
    burst_cnt_nxt  = burst_cnt;
    wr_go          = 1'b0;
    wr_sel         = '0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_full && rr_hit) begin
          wr_go          = 1'b1;
          wr_sel         = rr_idx;
          last_grant_nxt = rr_idx;
          if (lock[rr_idx] && (MAX_BURST > 1)) begin
            state_nxt     = ST_BURST;
            owner_nxt     = rr_idx;
            burst_cnt_nxt = CntW'(1);
          end
        end
      end
      ST_BURST: begin
        // last_grant already equals owner, so round-robin resumes after it.
        if (!req[owner]) begin
          state_nxt = ST_IDLE;
        end else if (!fifo_full) begin
          wr_go         = 1'b1;
          wr_sel        = owner;
          burst_cnt_nxt = burst_cnt_inc;
          if (!lock[owner] || (burst_cnt_inc == CntW'(MAX_BURST)))
            state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Outputs are combinational, so reset must mask them directly.
    if (reset) wr_go = 1'b0;
  end

  always_comb begin
    ack = '0;
    if (wr_go) ack[wr_sel] = 1'b1;
  end

  assign fifo_w_enb = wr_go;
  assign fifo_din   = wr_go ? din_bus[int'(wr_sel) * Width +: Width] : '0;
  assign grant_id   = wr_go ? wr_sel : '0;
  assign busy       = (state == ST_BURST) && !reset;

`ifdef FIFO_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if ((|req) && fifo_full && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int N     = 4;
  localparam int W     = 16;
  localparam int MAXB  = 4;
  localparam int DEPTH = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, lock, ack;
  logic [N*W-1:0] din_bus;
  logic           fifo_full, fifo_w_enb, busy;
  logic [W-1:0]   fifo_din;
  logic [1:0]     grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]    stall_cnt;
`endif

  fifo_wr_arbiter #(.NUM_REQ(N), .Width(W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .din_bus(din_bus),
    .ack(ack), .fifo_full(fifo_full), .fifo_w_enb(fifo_w_enb),
    .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
`ifdef FIFO_ARB_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Bench-side state
  logic         rd, force_full;
  logic [W-1:0] fq[$];       // what the DUT actually wrote into the FIFO
  logic [W-1:0] eq[$];       // what should be in the FIFO
  logic [W-1:0] pop_log[$];
  // Behavioural model: who spoke last, and who (if anyone) holds the port
  int           m_last, m_owner, m_words, m_e;
  bit           m_locked;
  int           m_stall;
  // Samples from the last cycle
  logic [N-1:0] s_ack;
  logic         s_wen, s_busy;
  logic [W-1:0] s_din;
  int           s_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_last = N - 1; m_locked = 0; m_owner = 0; m_words = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, then advance model and FIFO.
  task automatic cycle();
    logic [W-1:0] a, x, exp_din;
    fifo_full = force_full || (fq.size() >= DEPTH);
    @(negedge clk);
    m_e = -1;
    if (!reset) begin
      if (!m_locked) begin
        if (!fifo_full)
          for (int k = 1; k <= N; k++)
            if (m_e < 0 && req[(m_last + k) % N]) m_e = (m_last + k) % N;
      end else if (req[m_owner] && !fifo_full) begin
        m_e = m_owner;
      end
    end
    exp_din = (m_e >= 0) ? din_bus[m_e*W +: W] : '0;
    s_ack = ack; s_wen = fifo_w_enb; s_din = fifo_din; s_busy = busy;
    chk("ack",      32'(ack),        (m_e >= 0) ? (32'd1 << m_e) : 32'd0);
    chk("w_enb",    32'(fifo_w_enb), 32'(m_e >= 0));
    chk("din",      32'(fifo_din),   32'(exp_din));
    chk("grant_id", 32'(grant_id),   (m_e >= 0) ? 32'(m_e) : 32'd0);
    chk("busy",     32'(busy),       32'(m_locked && !reset));
    chk("no_write_when_full", 32'(fifo_w_enb && fifo_full), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    s_stall = int'(stall_cnt);
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
    @(posedge clk);
    if (reset) begin
      model_reset();
      m_stall = 0;
    end else begin
      if ((|req) && fifo_full && m_stall < 16'hFFFF) m_stall++;
      if (!m_locked) begin
        if (m_e >= 0) begin
          m_last = m_e;
          eq.push_back(exp_din);
          if (lock[m_e] && MAXB > 1) begin m_locked = 1; m_owner = m_e; m_words = 1; end
        end
      end else if (!req[m_owner]) begin
        m_locked = 0;
      end else if (m_e >= 0) begin
        m_words++;
        eq.push_back(exp_din);
        if (!lock[m_owner] || m_words == MAXB) m_locked = 0;
      end
    end
    if (rd && fq.size() > 0) begin
      a = fq.pop_front();
      pop_log.push_back(a);
      if (eq.size() == 0) chk("fifo_rd_extra", 32'(a), 32'hDEAD_0000);
      else begin x = eq.pop_front(); chk("fifo_rd", 32'(a), 32'(x)); end
    end
    if (s_wen) begin
      if (fq.size() >= DEPTH) chk("fifo_overflow", fq.size(), DEPTH - 1);
      fq.push_back(s_din);
    end
    #1;
  endtask

  task automatic drain();
    req = '0; lock = '0; rd = 1'b1;
    repeat (DEPTH + 2) cycle();
  endtask

  logic [N-1:0] fair_ack [5];
  logic [W-1:0] fair_rb  [5];
  logic [N-1:0] bst_ack  [5];
  logic         bst_busy [5];
  int           n, st0;

  initial begin
    fair_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    fair_rb  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h1111};
    bst_ack  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0100};
    bst_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    model_reset();
    m_stall = 0; s_stall = 0;
    reset = 1'b1; req = 4'b1111; lock = '0; rd = 1'b0; force_full = 1'b0;
    din_bus = {16'h4444, 16'h3333, 16'h2222, 16'h1111};

    // Reset with all requesting
    repeat (2) begin
      cycle();
      chk("rst_wen", 32'(s_wen), 32'd0);
      chk("rst_ack", 32'(s_ack), 32'd0);
      chk("rst_busy", 32'(s_busy), 32'd0);
    end
    reset = 1'b0;

    // Fairness
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("fair_ack", 32'(s_ack), 32'(fair_ack[i]));
    end
    pop_log.delete();
    drain();
    chk("fair_rb_count", pop_log.size(), 5);
    for (int i = 0; i < 5 && i < pop_log.size(); i++)
      chk("fair_rb", 32'(pop_log[i]), 32'(fair_rb[i]));

    // Locked burst from producer 1, producer 2 waiting
    req = 4'b0110; lock = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("burst_ack", 32'(s_ack), 32'(bst_ack[i]));
      chk("burst_busy", 32'(s_busy), 32'(bst_busy[i]));
    end
    drain();

    // Fill the FIFO from producer 0
    req = 4'b0001; lock = '0; rd = 1'b0;
    n = 0;
    while (fq.size() < DEPTH && n < 20) begin cycle(); n++; end
    chk("fill_reached", fq.size(), DEPTH);
    repeat (3) begin
      cycle();
      chk("full_wen", 32'(s_wen), 32'd0);
      chk("full_ack", 32'(s_ack), 32'd0);
    end
    rd = 1'b1; cycle(); rd = 1'b0;
    cycle();
    chk("one_slot_wen", 32'(s_wen), 32'd1);
    chk("one_slot_ack", 32'(s_ack), 32'b0001);
    cycle();
    chk("refull_wen", 32'(s_wen), 32'd0);
    drain();

    // Producer 3 burst, stalled by full, then exits on lock drop
    req = 4'b1000; lock = 4'b1000;
    cycle(); chk("st_ack0", 32'(s_ack), 32'b1000);
    cycle(); chk("st_ack1", 32'(s_ack), 32'b1000);
    chk("st_busy1", 32'(s_busy), 32'd1);
    st0 = s_stall;
    force_full = 1'b1;
    repeat (3) begin
      cycle();
      chk("stall_ack", 32'(s_ack), 32'd0);
      chk("stall_busy", 32'(s_busy), 32'd1);
    end
    force_full = 1'b0; lock = '0;
    cycle(); chk("exit_ack", 32'(s_ack), 32'b1000);
`ifdef FIFO_ARB_STATS_EN
    chk("stall_delta", 32'(s_stall - st0), 32'd3);
`endif
    req = '0;
    cycle(); chk("exit_busy", 32'(s_busy), 32'd0);
    drain();

    // Reset in the middle of a producer-2 burst
    req = 4'b0100; lock = 4'b0100;
    cycle(); chk("mb_ack", 32'(s_ack), 32'b0100);
    cycle(); chk("mb_busy", 32'(s_busy), 32'd1);
    reset = 1'b1; req = 4'b1111; lock = '0;
    cycle(); chk("mb_rst_busy", 32'(s_busy), 32'd0);
    reset = 1'b0;
    cycle();
    chk("mb_first_ack", 32'(s_ack), 32'b0001);
    chk("mb_idle_busy", 32'(s_busy), 32'd0);
`ifdef FIFO_ARB_STATS_EN
    chk("mb_stall_clear", 32'(s_stall), 32'd0);
`endif
    drain();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rd = ($urandom_range(0, 1) == 1);
      force_full = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) begin
        if (i == m_e) begin
          if ($urandom_range(0, 1) == 1) din_bus[i*W +: W] = W'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          din_bus[i*W +: W] = W'($urandom);
        end
        lock[i] = ($urandom_range(0, 3) != 0);
      end
      cycle();
    end
    reset = 1'b0; force_full = 1'b0;
    drain();
    chk("fifo_end_level", fq.size(), eq.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
